vga_timing: RTL and testbench

//  Free-running VGA 640x480@60 raster timing generator; directly upstream of the text/graphics pixel stage.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_sync_delay.sv | 32 +++
 rtl/vga_timing.sv | 127 ++++++++++++
 tb/tb_vga_timing.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, sync polarities and the raster-term bundle
// that travels through the output delay line.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic HSYNC_ACTIVE = 1'b0;
  localparam logic VSYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } raster_t;

  localparam raster_t RASTER_IDLE = '{vis: 1'b0, hs: ~HSYNC_ACTIVE, vs: ~VSYNC_ACTIVE};

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-tick-enabled delay line for the {vis, hs, vs} raster terms; every stage
// resets to the inactive pattern so no spurious sync appears after reset.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  raster_t d,
  output raster_t q
);

  if (DEPTH == 0) begin : g_bypass
    assign q = d;
  end else begin : g_pipe
    raster_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RASTER_IDLE;
      end else if (en) begin
        stage_q[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA raster generator: pixel-tick divider, row/colu counters, sync decode,
// delayed col_en/hsync/vsync, and the sticky vblank interrupt with frame counter.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 2,
  parameter int H_VIS      = H_VISIBLE,
  parameter int H_FP       = H_FRONT,
  parameter int H_SW       = H_SYNC,
  parameter int H_BP       = H_BACK,
  parameter int V_VIS      = V_VISIBLE,
  parameter int V_FP       = V_FRONT,
  parameter int V_SW       = V_SYNC,
  parameter int V_BP       = V_BACK
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pix_ce,
  output logic [31:0] row,
  output logic [31:0] colu,
  output logic        col_en,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] frame_cnt,
  output logic        vblank_irq,
  input  logic        irq_ack
);

  localparam int H_TOT    = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SW + V_BP;
  localparam int HS_FIRST = H_VIS + H_FP;
  localparam int HS_LAST  = HS_FIRST + H_SW - 1;
  localparam int VS_FIRST = V_VIS + V_FP;
  localparam int VS_LAST  = VS_FIRST + V_SW - 1;
  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  logic [1:0]  div_q, div_d;
  logic        pix_ce_q, pix_ce_d;
  logic [31:0] row_q, row_d;
  logic [31:0] colu_q, colu_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        irq_q, irq_d;
  logic        line_end, frame_end, vblank_evt;
  raster_t     raster, raster_dly;

  // pix_ce is registered, so it rises the cycle after the divider wraps.
  always_comb begin
    div_d    = div_q + 2'd1;
    pix_ce_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d    = '0;
      pix_ce_d = 1'b1;
    end
  end

  always_comb begin
    row_d       = row_q;
    colu_d      = colu_q;
    frame_cnt_d = frame_cnt_q;
    irq_d       = irq_q;
    line_end    = (row_q == 32'(H_TOT - 1));
    frame_end   = (colu_q == 32'(V_TOT - 1));
    vblank_evt  = pix_ce_q && line_end && (colu_q == 32'(V_VIS - 1));

    if (pix_ce_q) begin
      if (line_end) begin
        row_d  = '0;
        colu_d = frame_end ? '0 : colu_q + 32'd1;
      end else begin
        row_d = row_q + 32'd1;
      end
    end

    // A new vblank outranks a simultaneous acknowledge.
    if (vblank_evt) begin
      irq_d       = 1'b1;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      pix_ce_q    <= 1'b0;
      row_q       <= '0;
      colu_q      <= '0;
      frame_cnt_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      div_q       <= div_d;
      pix_ce_q    <= pix_ce_d;
      row_q       <= row_d;
      colu_q      <= colu_d;
      frame_cnt_q <= frame_cnt_d;
      irq_q       <= irq_d;
    end
  end

  always_comb begin
    raster.vis = (row_q < 32'(H_VIS)) && (colu_q < 32'(V_VIS));
    raster.hs  = ((row_q >= 32'(HS_FIRST)) && (row_q <= 32'(HS_LAST))) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
    raster.vs  = ((colu_q >= 32'(VS_FIRST)) && (colu_q <= 32'(VS_LAST))) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
  end

  vga_sync_delay #(
    .DEPTH (PIPE_DELAY)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_ce_q),
    .d     (raster),
    .q     (raster_dly)
  );

  assign pix_ce     = pix_ce_q;
  assign row        = row_q;
  assign colu       = colu_q;
  assign col_en     = raster_dly.vis;
  assign hsync      = raster_dly.hs;
  assign vsync      = raster_dly.vs;
  assign frame_cnt  = frame_cnt_q;
  assign vblank_irq = irq_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing on a shrunken raster so whole frames fit in a short run; outputs are
// compared every clock against a tick-count model of the raster.
module tb_vga_timing;

  localparam int D   = 2;
  localparam int PD  = 2;
  localparam int HV  = 16;
  localparam int HF  = 2;
  localparam int HS  = 3;
  localparam int HB  = 3;
  localparam int HT  = HV + HF + HS + HB;
  localparam int VV  = 10;
  localparam int VF  = 2;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int VT  = VV + VF + VS + VB;
  localparam int FT  = HT * VT;
  localparam int LINE_CLK = D * HT;
  localparam int EV0 = D * (VV * HT) + 1;
  localparam int EV1 = EV0 + D * FT;
  localparam int EV2 = EV1 + D * FT;
  localparam int EV3 = EV2 + D * FT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq_ack = 1'b0;
  logic        pix_ce, col_en, hsync, vsync, vblank_irq;
  logic [31:0] row, colu;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  vga_timing #(
    .CLK_DIV    (D),
    .PIPE_DELAY (PD),
    .H_VIS (HV), .H_FP (HF), .H_SW (HS), .H_BP (HB),
    .V_VIS (VV), .V_FP (VF), .V_SW (VS), .V_BP (VB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_ce     (pix_ce),
    .row        (row),
    .colu       (colu),
    .col_en     (col_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_cnt  (frame_cnt),
    .vblank_irq (vblank_irq),
    .irq_ack    (irq_ack)
  );

  typedef struct {
    int          tgtClk;
    logic        ack;
    logic        expIrq;
    logic [15:0] expFrame;
    string       name;
  } vec_t;

  int checks = 0;
  int passes = 0;

  // model: clocks and pixel ticks since reset release
  int          mc, mt;
  logic        mirq;
  logic [15:0] mframes;

  logic statOn = 1'b0;
  logic hsPrev;
  int   colEnCnt, hsLow, vsLow, firstColEn, firstHsRow, lastFall, hsPeriod;

  task automatic checkVal(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int expRow(input int t);
    return t % HT;
  endfunction

  function automatic int expColu(input int t);
    return (t / HT) % VT;
  endfunction

  // {vis, hs, vs} shown after tick t: raster position t-PD, inactive before the line fills
  function automatic logic [2:0] expTerms(input int t);
    int k, r, c;
    k = t - PD;
    if (k < 0) return 3'b011;
    r = expRow(k);
    c = expColu(k);
    return {(r < HV) && (c < VV), !(r >= HV + HF && r < HV + HF + HS), !(c >= VV + VF && c < VV + VF + VS)};
  endfunction

  task automatic checkOutput();
    logic [2:0] terms;
    terms = expTerms(mt);
    checkVal("pix_ce", pix_ce, (mc > 0) && (mc % D == 0));
    checkVal("row", row, expRow(mt));
    checkVal("colu", colu, expColu(mt));
    checkVal("col_en", col_en, terms[2]);
    checkVal("hsync", hsync, terms[1]);
    checkVal("vsync", vsync, terms[0]);
    checkVal("frame_cnt", frame_cnt, mframes);
    checkVal("vblank_irq", vblank_irq, mirq);
  endtask

  task automatic modelReset();
    mc = 0; mt = 0; mirq = 1'b0; mframes = 16'd0;
  endtask

  task automatic applyStimulus();
    logic pce, evt;
    pce = (mc > 0) && (mc % D == 0);
    @(posedge clk);
    evt = 1'b0;
    if (pce) begin
      mt++;
      evt = (expRow(mt) == 0) && (expColu(mt) == VV);
    end
    if (evt) begin
      mirq = 1'b1;
      mframes = mframes + 16'd1;
    end else if (irq_ack) begin
      mirq = 1'b0;
    end
    mc++;
    #1;
    checkOutput();
    if (statOn) begin
      if (firstColEn < 0 && col_en) firstColEn = mt;
      if (pce && mt > PD && mt <= PD + FT) begin
        if (col_en) colEnCnt++;
        if (!hsync) hsLow++;
        if (!vsync) vsLow++;
        if (!hsync && hsPrev) begin
          if (firstHsRow < 0) firstHsRow = int'(row);
          if (lastFall >= 0 && hsPeriod < 0) hsPeriod = mt - lastFall;
          lastFall = mt;
        end
        hsPrev = hsync;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    logic expPce[6];
    int   expRowSeq[6];

    vecs[0] = '{EV0 - 1,                0, 0, 16'd0, "before_vblank"};
    vecs[1] = '{EV0,                    0, 1, 16'd1, "vblank_set"};
    vecs[2] = '{EV0 + 3 * LINE_CLK,     0, 1, 16'd1, "irq_hold_3_lines"};
    vecs[3] = '{EV0 + 3 * LINE_CLK + 1, 1, 0, 16'd1, "irq_ack_clear"};
    vecs[4] = '{EV0 + 3 * LINE_CLK + 2, 1, 0, 16'd1, "ack_while_clear"};
    vecs[5] = '{EV1 - 1,                0, 0, 16'd1, "before_second"};
    vecs[6] = '{EV1,                    0, 1, 16'd2, "second_frame"};
    expPce    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    expRowSeq = '{0, 0, 1, 1, 2, 2};

    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput();

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkVal("start_pix_ce", pix_ce, expPce[i]);
      checkVal("start_row", row, expRowSeq[i]);
    end

    for (int i = 0; i < 7; i++) begin
      while (mc < vecs[i].tgtClk - 1) applyStimulus();
      irq_ack = vecs[i].ack;
      applyStimulus();
      irq_ack = 1'b0;
      checkVal({vecs[i].name, "_irq"}, vblank_irq, vecs[i].expIrq);
      checkVal({vecs[i].name, "_frame"}, frame_cnt, vecs[i].expFrame);
    end

    irq_ack = 1'b1;
    applyStimulus();
    irq_ack = 1'b0;
    checkVal("pre_race_clear", vblank_irq, 0);
    while (mc < EV2 - 1) applyStimulus();
    irq_ack = 1'b1;
    applyStimulus();
    irq_ack = 1'b0;
    checkVal("ack_vs_set_irq", vblank_irq, 1);
    checkVal("ack_vs_set_frame", frame_cnt, 3);
    irq_ack = 1'b1;
    applyStimulus();
    irq_ack = 1'b0;

    mframes = 16'hFFFF;
    force dut.frame_cnt_q = 16'hFFFF;
    applyStimulus();
    applyStimulus();
    release dut.frame_cnt_q;
    while (mc < EV3) applyStimulus();
    checkVal("frame_wrap", frame_cnt, 0);
    checkVal("frame_wrap_irq", vblank_irq, 1);

    for (int i = 0; i < 2 * D * FT && !(expRow(mt) == 12 && expColu(mt) == 6); i++) applyStimulus();
    checkVal("mid_frame_row", row, 12);
    checkVal("mid_frame_colu", colu, 6);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();

    colEnCnt = 0; hsLow = 0; vsLow = 0; firstColEn = -1; firstHsRow = -1;
    lastFall = -1; hsPeriod = -1; hsPrev = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    statOn = 1'b1;
    for (int i = 0; i < D * (FT + PD + 4) && mt <= PD + FT; i++) applyStimulus();
    statOn = 1'b0;
    checkVal("col_en_ticks", colEnCnt, HV * VV);
    checkVal("hsync_low_ticks", hsLow, HS * VT);
    checkVal("vsync_low_ticks", vsLow, VS * HT);
    checkVal("first_col_en_tick", firstColEn, PD);
    checkVal("first_hsync_low_row", firstHsRow, (HV + HF + PD) % HT);
    checkVal("hsync_period", hsPeriod, HT);

    for (int i = 0; i < 800; i++) begin
      irq_ack = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end
    irq_ack = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
